// File: rtl/trg_link_pkg.sv
// Trigger link shared definitions: sequencer state encoding,
// counter width and default phase-alignment timing.
package trg_link_pkg;

  localparam int CNT_W            = 14;
  localparam int ALIGN_WAIT_DEF   = 32;
  localparam int PHASE_CYCLES_DEF = 8192;
  localparam int OUT_W            = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W4RSTDONE = 3'd1,
    ST_ALIGNWAIT = 3'd2,
    ST_PHASESET  = 3'd3,
    ST_DONE      = 3'd4
  } sync_state_e;

  // Output bundle {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE}
  function automatic logic [OUT_W-1:0] out_decode(
    input sync_state_e s
  );
    logic [OUT_W-1:0] o;
    o = '0;
    unique case (1'b1)
      (s == ST_ALIGNWAIT): o = 3'b100;
      (s == ST_PHASESET):  o = 3'b110;
      (s == ST_DONE):      o = 3'b101;
      default:             o = 3'b000;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
// Ports: a, b, c copies in; y voted value out.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  (* keep = "true" *) logic [W-1:0] maj;

  assign maj = (a & b) | (a & c) | (b & c);
  assign y   = maj;

endmodule

// File: rtl/gtx_tx_sync_fsm.sv
// Triplicated GTX TX PMA phase-alignment sequencer.
// Ports: CLK, RST (async, high), GTX_RST restart, TX_RST_DONE
// (async) in; TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE out.
module gtx_tx_sync_fsm
  import trg_link_pkg::*;
#(
  parameter int ALIGN_WAIT   = ALIGN_WAIT_DEF,
  parameter int PHASE_CYCLES = PHASE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic GTX_RST,
  input  logic TX_RST_DONE,
  output logic TXENPMAPHASEALIGN,
  output logic TXPMASETPHASE,
  output logic SYNC_DONE
);

  localparam logic [CNT_W-1:0] AW_LAST =
    CNT_W'(ALIGN_WAIT - 1);
  localparam logic [CNT_W-1:0] PC_LAST =
    CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  logic sync1;
  logic rst_done_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1      <= 1'b0;
      rst_done_s <= 1'b0;
    end else begin
      sync1      <= TX_RST_DONE;
      rst_done_s <= sync1;
    end
  end

  logic [2:0][2:0]       st_r;
  logic [2:0][CNT_W-1:0] cnt_r;
  logic [2:0][OUT_W-1:0] out_r;

  for (genvar i = 0; i < 3; i++) begin : g_copy
    logic [2:0]       st_vb;
    logic [CNT_W-1:0] cnt_v;
    sync_state_e      st_v;
    sync_state_e      st_n;
    logic [CNT_W-1:0] cnt_n;

    (* keep = "true" *) sync_state_e      st_q;
    (* keep = "true" *) logic [CNT_W-1:0] cnt_q;
    (* keep = "true" *) logic [OUT_W-1:0] out_q;

    assign st_r[i]  = st_q;
    assign cnt_r[i] = cnt_q;
    assign out_r[i] = out_q;

    // Each copy votes on its own so one bad voter
    // only corrupts one copy.
    tmr_vote #(.W(3)) u_vote_st (
      .a (st_r[0]),
      .b (st_r[1]),
      .c (st_r[2]),
      .y (st_vb)
    );

    tmr_vote #(.W(CNT_W)) u_vote_cnt (
      .a (cnt_r[0]),
      .b (cnt_r[1]),
      .c (cnt_r[2]),
      .y (cnt_v)
    );

    assign st_v = sync_state_e'(st_vb);

    always_comb begin
      st_n = ST_IDLE;
      if (GTX_RST) begin
        st_n = ST_IDLE;
      end else begin
        case (st_v)
          ST_IDLE:
            st_n = ST_W4RSTDONE;
          ST_W4RSTDONE:
            st_n = rst_done_s ? ST_ALIGNWAIT
                              : ST_W4RSTDONE;
          ST_ALIGNWAIT:
            if (!rst_done_s)
              st_n = ST_W4RSTDONE;
            else if (cnt_v == AW_LAST)
              st_n = ST_PHASESET;
            else
              st_n = ST_ALIGNWAIT;
          ST_PHASESET:
            if (!rst_done_s)
              st_n = ST_W4RSTDONE;
            else if (cnt_v == PC_LAST)
              st_n = ST_DONE;
            else
              st_n = ST_PHASESET;
          ST_DONE:
            st_n = rst_done_s ? ST_DONE
                              : ST_W4RSTDONE;
          default:
            st_n = ST_IDLE;
        endcase
      end
    end

    always_comb begin
      cnt_n = '0;
      if (st_n == st_v &&
          (st_v == ST_ALIGNWAIT ||
           st_v == ST_PHASESET))
        cnt_n = cnt_v + CNT_ONE;
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
        out_q <= '0;
      end else begin
        st_q  <= st_n;
        cnt_q <= cnt_n;
        out_q <= out_decode(st_n);
      end
    end
  end

  logic [OUT_W-1:0] out_v;

  tmr_vote #(.W(OUT_W)) u_vote_out (
    .a (out_r[0]),
    .b (out_r[1]),
    .c (out_r[2]),
    .y (out_v)
  );

  assign TXENPMAPHASEALIGN = out_v[2];
  assign TXPMASETPHASE     = out_v[1];
  assign SYNC_DONE         = out_v[0];

endmodule

// File: tb/tb_gtx_tx_sync_fsm.sv
// Scoreboard bench for gtx_tx_sync_fsm: expected output
// changes are queued with their cycle and matched on change.
module tb_gtx_tx_sync_fsm;
  import trg_link_pkg::*;

  localparam int AW = 32;
  localparam int PC = 8192;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic GTX_RST = 1'b0;
  logic TX_RST_DONE = 1'b0;
  logic en, setp, done;

  gtx_tx_sync_fsm #(
    .ALIGN_WAIT   (AW),
    .PHASE_CYCLES (PC)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .GTX_RST           (GTX_RST),
    .TX_RST_DONE       (TX_RST_DONE),
    .TXENPMAPHASEALIGN (en),
    .TXPMASETPHASE     (setp),
    .SYNC_DONE         (done)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  val;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  logic [2:0] prev = 3'b000;

  task automatic push(input int unsigned c,
                      input logic [2:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input int unsigned a);
    push(a, 3'b100);
    push(a + AW, 3'b110);
    push(a + AW + PC, 3'b101);
  endtask

  always @(negedge CLK) begin
    logic [2:0] cur;
    exp_t e;
    if (mon_en) begin
      cur = {en, setp, done};
      while (exp_q.size() != 0 &&
             exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_change cyc=%0d want=%b@%0d",
                 cyc, e.val, e.cyc);
      end
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b",
                   cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            bad++;
            $display("FAIL out_change got=%b@%0d want=%b@%0d",
                     cur, cyc, e.val, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic drain(input string nm,
                       input int budget);
    int n = budget;
    while (exp_q.size() != 0 && n > 0) begin
      @(negedge CLK);
      n--;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout pending=%0d want=0",
               nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    total++;
    if ({en, setp, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_out got=%b want=000",
               {en, setp, done});
    end
    total++;
    if (dut.g_copy[0].st_q !== ST_IDLE ||
        dut.g_copy[1].st_q !== ST_IDLE ||
        dut.g_copy[2].st_q !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d want=%0d",
               dut.g_copy[0].st_q, ST_IDLE);
    end
    total++;
    if (dut.g_copy[1].cnt_q !== '0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0",
               dut.g_copy[1].cnt_q);
    end
  endtask

  task automatic test_normal();
    int unsigned b;
    @(negedge CLK);
    RST = 1'b0;
    b = cyc;
    prev = 3'b000;
    mon_en = 1'b1;
    @(negedge CLK);
    total++;
    if (dut.g_copy[2].st_q !== ST_W4RSTDONE) begin
      bad++;
      $display("FAIL idle_to_w4 got=%0d want=%0d",
               dut.g_copy[2].st_q, ST_W4RSTDONE);
    end
    wait_until(b + 10);
    TX_RST_DONE = 1'b1;
    push_seq(b + 13);
    drain("normal", PC + 200);
    repeat (5) @(negedge CLK);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_hold got=%b want=1", done);
    end
  endtask

  task automatic test_restart();
    int unsigned p;
    @(negedge CLK);
    p = cyc;
    GTX_RST = 1'b1;
    push(p + 1, 3'b000);
    repeat (5) @(negedge CLK);
    GTX_RST = 1'b0;
    push(p + 7, 3'b100);
    push(p + 7 + AW, 3'b110);
    wait_until(p + 7 + AW + 4000);
    p = cyc;
    GTX_RST = 1'b1;
    push(p + 1, 3'b000);
    @(negedge CLK);
    total++;
    if ({en, setp, done} !== 3'b000) begin
      bad++;
      $display("FAIL restart_clear got=%b want=000",
               {en, setp, done});
    end
    repeat (4) @(negedge CLK);
    GTX_RST = 1'b0;
    push_seq(p + 7);
    drain("restart", PC + 200);
  endtask

  task automatic test_rstdone_loss();
    int unsigned t;
    @(negedge CLK);
    t = cyc;
    TX_RST_DONE = 1'b0;
    push(t + 3, 3'b000);
    wait_until(t + 2);
    total++;
    if ({en, setp, done} !== 3'b101) begin
      bad++;
      $display("FAIL loss_early got=%b want=101",
               {en, setp, done});
    end
    wait_until(t + 3);
    total++;
    if (dut.g_copy[0].st_q !== ST_W4RSTDONE) begin
      bad++;
      $display("FAIL loss_state got=%0d want=%0d",
               dut.g_copy[0].st_q, ST_W4RSTDONE);
    end
    wait_until(t + 10);
    TX_RST_DONE = 1'b1;
    push_seq(t + 13);
    drain("loss_reassert", PC + 200);
  endtask

  task automatic test_seu();
    int unsigned p;
    @(negedge CLK);
    p = cyc;
    GTX_RST = 1'b1;
    push(p + 1, 3'b000);
    @(negedge CLK);
    GTX_RST = 1'b0;
    push_seq(p + 3);
    wait_until(p + 8);
    dut.g_copy[1].st_q = ST_PHASESET;
    #1;
    total++;
    if ({en, setp, done} !== 3'b100) begin
      bad++;
      $display("FAIL seu_state_out got=%b want=100",
               {en, setp, done});
    end
    @(negedge CLK);
    total++;
    if (dut.g_copy[0].st_q !== ST_ALIGNWAIT ||
        dut.g_copy[1].st_q !== ST_ALIGNWAIT ||
        dut.g_copy[2].st_q !== ST_ALIGNWAIT) begin
      bad++;
      $display("FAIL seu_state_fix got=%0d want=%0d",
               dut.g_copy[1].st_q, ST_ALIGNWAIT);
    end
    wait_until(p + 14);
    dut.g_copy[2].cnt_q = dut.g_copy[2].cnt_q ^ 14'h0010;
    @(negedge CLK);
    total++;
    if (dut.g_copy[2].cnt_q !== dut.g_copy[0].cnt_q ||
        dut.g_copy[1].cnt_q !== dut.g_copy[0].cnt_q) begin
      bad++;
      $display("FAIL seu_cnt_fix got=%0d want=%0d",
               dut.g_copy[2].cnt_q, dut.g_copy[0].cnt_q);
    end
    drain("seu_timing", PC + 200);
  endtask

  task automatic test_simultaneous();
    int unsigned t;
    int unsigned u;
    @(negedge CLK);
    t = cyc;
    TX_RST_DONE = 1'b0;
    push(t + 3, 3'b000);
    wait_until(t + 6);
    u = cyc;
    TX_RST_DONE = 1'b1;
    wait_until(u + 2);
    GTX_RST = 1'b1;
    total++;
    if (dut.rst_done_s !== 1'b1) begin
      bad++;
      $display("FAIL sim_sync got=%b want=1",
               dut.rst_done_s);
    end
    wait_until(u + 3);
    total++;
    if (dut.g_copy[1].st_q !== ST_IDLE ||
        {en, setp, done} !== 3'b000) begin
      bad++;
      $display("FAIL sim_idle got=%0d/%b want=%0d/000",
               dut.g_copy[1].st_q, {en, setp, done},
               ST_IDLE);
    end
    GTX_RST = 1'b0;
    push(u + 5, 3'b100);
    push(u + 5 + AW, 3'b110);
    drain("sim_restart", AW + 100);
    repeat (100) @(negedge CLK);
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    mon_en = 1'b0;
    total++;
    if (setp !== 1'b1) begin
      bad++;
      $display("FAIL async_pre got=%b want=1", setp);
    end
    #2;
    RST = 1'b1;
    #1;
    total++;
    if ({en, setp, done} !== 3'b000) begin
      bad++;
      $display("FAIL async_out got=%b want=000",
               {en, setp, done});
    end
    total++;
    if (dut.g_copy[0].cnt_q !== '0 ||
        dut.g_copy[2].st_q !== ST_IDLE) begin
      bad++;
      $display("FAIL async_state got=%0d/%0d want=0/0",
               dut.g_copy[0].cnt_q, dut.g_copy[2].st_q);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_restart();
    test_rstdone_loss();
    test_seu();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
